// File: rtl/luna_pkg.sv
// Shared definitions for the instruction fetch path: FSM encoding and default
// address/data widths.
package luna_pkg;

    localparam int LUNA_ADDR_W = 16;
    localparam int LUNA_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Wait-cycle counter for outstanding fetches; expire_o flags the last WAIT
// cycle that may still complete before the request is abandoned.
module fetch_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps the PC, issues one memory read per fetch
// strobe, latches the returned word and traps into ERR on memory timeout.
module fetch_unit
    import luna_pkg::*;
#(
    parameter int ADDR_W   = LUNA_ADDR_W,
    parameter int DATA_W   = LUNA_DATA_W,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_clk,
    input  logic              jmp_clk,
    input  logic              jmp_taken,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_err,
    output fetch_state_t      dbg_state
);

    // Memory handshake: mem_req rises with mem_addr and both hold steady until
    // a cycle where mem_ack is sampled high; that cycle carries mem_rdata.

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] instr_q;
    logic              instr_valid_q;
    logic              busy_q;
    logic              fetch_err_q;
    logic              timer_expire;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q != ST_WAIT),
        .enable_i ((state_q == ST_WAIT) && !mem_ack),
        .expire_o (timer_expire)
    );

    // PC advances independently of the fetch state, but freezes once trapped.
    always_comb begin
        pc_d = pc_q;
        if (jmp_clk && (state_q != ST_ERR)) begin
            pc_d = jmp_taken ? jmp_target : pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= ADDR_W'(RESET_PC);
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                ST_IDLE: begin
                    if (fetch_clk) begin
                        state_q       <= ST_WAIT;
                        mem_req_q     <= 1'b1;
                        mem_addr_q    <= pc_q;
                        instr_valid_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // An ack on the final permitted cycle still beats the timeout.
                    if (mem_ack) begin
                        state_q       <= ST_IDLE;
                        mem_req_q     <= 1'b0;
                        instr_q       <= mem_rdata;
                        instr_valid_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end else if (timer_expire) begin
                        state_q     <= ST_ERR;
                        mem_req_q   <= 1'b0;
                        busy_q      <= 1'b0;
                        fetch_err_q <= 1'b1;
                    end
                end
                ST_ERR: begin
                    state_q <= ST_ERR;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign fetch_err   = fetch_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table for the main behaviours plus hand-built
// sequences for timeout, trap and reset corner cases.
module tb_fetch_unit;
  import luna_pkg::*;

  typedef logic [53:0] obs_t;

  typedef struct {
    logic        f;
    logic        j;
    logic        t;
    logic [15:0] tg;
    logic        a;
    logic [15:0] rd;
    obs_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_clk = 1'b0;
  logic        jmp_clk = 1'b0;
  logic        jmp_taken = 1'b0;
  logic [15:0] jmp_target = 16'h0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc;
  logic        busy;
  logic        fetch_err;
  fetch_state_t dbg_state;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  obs_t obs;

  fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .RESET_PC (0),
    .TIMEOUT  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_clk   (fetch_clk),
    .jmp_clk     (jmp_clk),
    .jmp_taken   (jmp_taken),
    .jmp_target  (jmp_target),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .fetch_err   (fetch_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign obs = {mem_req, mem_addr, instr, instr_valid, pc, busy, fetch_err, 2'(dbg_state)};

  function automatic obs_t pk(input logic rq, input logic [15:0] ad, input logic [15:0] in,
                              input logic v, input logic [15:0] p, input logic b,
                              input logic e, input logic [1:0] s);
    return {rq, ad, in, v, p, b, e, s};
  endfunction

  function automatic vec_t mk(input logic f, input logic j, input logic t, input logic [15:0] tg,
                              input logic a, input logic [15:0] rd, input obs_t exp);
    vec_t v;
    v.f = f; v.j = j; v.t = t; v.tg = tg; v.a = a; v.rd = rd; v.exp = exp;
    return v;
  endfunction

  // scoreboard
  task automatic check(input string name);
    obs_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got %h", name, obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        n_err++;
        $display("FAIL %s: got req=%b addr=%h instr=%h v=%b pc=%h busy=%b err=%b st=%0d, want req=%b addr=%h instr=%h v=%b pc=%h busy=%b err=%b st=%0d",
                 name, obs[53], obs[52:37], obs[36:21], obs[20], obs[19:4], obs[3], obs[2], obs[1:0],
                 e[53], e[52:37], e[36:21], e[20], e[19:4], e[3], e[2], e[1:0]);
      end
    end
  endtask

  // driver: called at a negedge, applies inputs across one rising edge
  task automatic step(input vec_t v, input string name);
    fetch_clk  = v.f;
    jmp_clk    = v.j;
    jmp_taken  = v.t;
    jmp_target = v.tg;
    mem_ack    = v.a;
    mem_rdata  = v.rd;
    exp_q.push_back(v.exp);
    @(posedge clk);
    @(negedge clk);
    fetch_clk = 1'b0;
    jmp_clk   = 1'b0;
    mem_ack   = 1'b0;
    check(name);
  endtask

  task automatic check_now(input obs_t e, input string name);
    exp_q.push_back(e);
    check(name);
  endtask

  vec_t vecs[17];
  obs_t zero_obs;
  obs_t w;

  initial begin
    zero_obs = pk(0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 2'd0);

    vecs[0]  = mk(0,0,0,16'h0000,0,16'h0000, pk(0,16'h0000,16'h0000,0,16'h0000,0,0,2'd0));
    vecs[1]  = mk(1,0,0,16'h0000,0,16'h0000, pk(1,16'h0000,16'h0000,0,16'h0000,1,0,2'd1));
    vecs[2]  = mk(0,0,0,16'h0000,0,16'h0000, pk(1,16'h0000,16'h0000,0,16'h0000,1,0,2'd1));
    vecs[3]  = mk(0,0,0,16'h0000,1,16'hA5A5, pk(0,16'h0000,16'hA5A5,1,16'h0000,0,0,2'd0));
    vecs[4]  = mk(0,0,0,16'h0000,1,16'h1111, pk(0,16'h0000,16'hA5A5,1,16'h0000,0,0,2'd0));
    vecs[5]  = mk(0,1,0,16'h0000,0,16'h0000, pk(0,16'h0000,16'hA5A5,1,16'h0001,0,0,2'd0));
    vecs[6]  = mk(0,1,1,16'h0010,0,16'h0000, pk(0,16'h0000,16'hA5A5,1,16'h0010,0,0,2'd0));
    vecs[7]  = mk(0,1,1,16'h0200,0,16'h0000, pk(0,16'h0000,16'hA5A5,1,16'h0200,0,0,2'd0));
    vecs[8]  = mk(1,0,0,16'h0000,0,16'h0000, pk(1,16'h0200,16'hA5A5,0,16'h0200,1,0,2'd1));
    vecs[9]  = mk(0,1,0,16'h0000,0,16'h0000, pk(1,16'h0200,16'hA5A5,0,16'h0201,1,0,2'd1));
    vecs[10] = mk(1,0,0,16'h0000,0,16'h0000, pk(1,16'h0200,16'hA5A5,0,16'h0201,1,0,2'd1));
    vecs[11] = mk(0,0,0,16'h0000,1,16'h1234, pk(0,16'h0200,16'h1234,1,16'h0201,0,0,2'd0));
    vecs[12] = mk(0,1,1,16'h0004,0,16'h0000, pk(0,16'h0200,16'h1234,1,16'h0004,0,0,2'd0));
    vecs[13] = mk(1,1,0,16'h0000,0,16'h0000, pk(1,16'h0004,16'h1234,0,16'h0005,1,0,2'd1));
    vecs[14] = mk(0,0,0,16'h0000,1,16'hBEEF, pk(0,16'h0004,16'hBEEF,1,16'h0005,0,0,2'd0));
    vecs[15] = mk(0,1,1,16'hFFFF,0,16'h0000, pk(0,16'h0004,16'hBEEF,1,16'hFFFF,0,0,2'd0));
    vecs[16] = mk(0,1,0,16'h0000,0,16'h0000, pk(0,16'h0004,16'hBEEF,1,16'h0000,0,0,2'd0));

    repeat (2) @(negedge clk);
    check_now(zero_obs, "reset_state");
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // no ack: eighth WAIT cycle traps
    w = pk(1,16'h0000,16'hBEEF,0,16'h0000,1,0,2'd1);
    step(mk(1,0,0,16'h0,0,16'h0,w), "to_fetch");
    for (int k = 1; k <= 7; k++) begin
      step(mk(0,0,0,16'h0,0,16'h0,w), $sformatf("to_wait%0d", k));
    end
    w = pk(0,16'h0000,16'hBEEF,0,16'h0000,0,1,2'd2);
    step(mk(0,0,0,16'h0,0,16'h0,w), "to_expire");
    step(mk(1,1,1,16'h0123,1,16'h7777,w), "err_all_strobes");
    step(mk(0,1,0,16'h0,0,16'h0,w), "err_jmp");
    step(mk(1,0,0,16'h0,1,16'h6666,w), "err_fetch_ack");

    @(negedge clk);
    rst = 1'b0;
    #1;
    check_now(zero_obs, "reset_from_err");
    @(negedge clk);
    rst = 1'b1;

    // ack on the eighth WAIT cycle wins over the timeout
    w = pk(1,16'h0000,16'h0000,0,16'h0000,1,0,2'd1);
    step(mk(1,0,0,16'h0,0,16'h0,w), "ack8_fetch");
    for (int k = 1; k <= 7; k++) begin
      step(mk(0,0,0,16'h0,0,16'h0,w), $sformatf("ack8_wait%0d", k));
    end
    w = pk(0,16'h0000,16'h5A5A,1,16'h0000,0,0,2'd0);
    step(mk(0,0,0,16'h0,1,16'h5A5A,w), "ack8_accept");
    step(mk(0,0,0,16'h0,0,16'h0,w), "ack8_no_err");

    // reset asserted mid-WAIT, then a late ack
    w = pk(0,16'h0000,16'h5A5A,1,16'h0300,0,0,2'd0);
    step(mk(0,1,1,16'h0300,0,16'h0,w), "rw_jmp");
    w = pk(1,16'h0300,16'h5A5A,0,16'h0300,1,0,2'd1);
    step(mk(1,0,0,16'h0,0,16'h0,w), "rw_fetch");
    step(mk(0,0,0,16'h0,0,16'h0,w), "rw_wait");
    #2;
    rst = 1'b0;
    #1;
    check_now(zero_obs, "rw_async_reset");
    mem_ack   = 1'b1;
    mem_rdata = 16'h9999;
    @(posedge clk);
    @(negedge clk);
    check_now(zero_obs, "rw_ack_in_reset");
    rst = 1'b1;
    step(mk(0,0,0,16'h0,1,16'h9999,zero_obs), "rw_late_ack");
    step(mk(0,0,0,16'h0,0,16'h0,zero_obs), "rw_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
